ysyx_22041412_trap_ctrl: RTL and testbench
==========================================

Name: ysyx_22041412_trap_ctrl

Overview:
Sequences machine-mode trap entry and return for the NPC core's CSR file: ecall, mret and machine timer interrupt.
Owns the single CSR write port and read port during a trap, performs the mepc/mcause/mstatus update sequence, then issues a PC redirect to the fetch stage.
Sits between the execute/writeback stage (trap requests), the CLINT (timer pending) and the CSR file.

Parameters:
XLEN, 64, datapath width
CSR_AW, 3, CSR file index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  core presents ecall or mret at commit
req_type  in  1  0=ecall, 1=mret
req_pc  in  XLEN  PC of the requesting instruction, or next PC for an interrupt
req_ready  out  1  request accepted this cycle
mtip  in  1  CLINT timer pending, level
irq_take  out  1  one-cycle pulse: interrupt accepted; core must squash its commit
busy  out  1  trap sequence in progress; core stalls commit and CSR instructions
csr_raddr  out  CSR_AW  CSR read index
csr_rdata  in  XLEN  combinational read data
csr_we  out  1  CSR write strobe
csr_waddr  out  CSR_AW  CSR write index
csr_wdata  out  XLEN  CSR write data
redirect_valid  out  1  one-cycle PC redirect pulse
redirect_pc  out  XLEN  redirect target

Behaviour:
- CSR indices: mstatus=1, mie=2, mtvec=3, mepc=4, mcause=5, mip=6.
- Reset outputs (async, immediate): state=IDLE. req_ready, irq_take, busy, csr_we and redirect_valid are 0. csr_raddr, csr_waddr, csr_wdata and redirect_pc are 0.
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, UPD_STATUS, RD_MTVEC, RESTORE, RD_MEPC, REDIRECT.
- IDLE:
  - Interrupt pending when mtip=1, mstatus[3] (MIE)=1 and mie[7] (MTIE)=1. csr_raddr cycles mstatus/mie each cycle; the two reads are latched into shadow regs.
  - Interrupt wins over req_valid in the same cycle: irq_take=1, req_ready=0, latch req_pc, cause=0x8000_0000_0000_0007, go to SAVE_EPC.
  - Otherwise req_valid with type ecall: req_ready=1, latch pc, cause=0xb, go to SAVE_EPC.
  - req_valid with type mret: req_ready=1, go to RESTORE.
- SAVE_EPC: csr_we=1, mepc <= latched pc with bit0 cleared.
- SAVE_CAUSE: csr_we=1, mcause <= cause.
- UPD_STATUS: read mstatus, write MPIE(bit7) <= MIE, MIE <= 0, MPP(bits12:11) <= 2'b11; all other bits unchanged.
- RD_MTVEC: read mtvec, target = mtvec with bits1:0 cleared, go to REDIRECT.
- RESTORE: read mstatus, write MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
- RD_MEPC: target = mepc, go to REDIRECT.
- REDIRECT: redirect_valid=1, redirect_pc=target, return to IDLE.
- busy=1 in every state except IDLE.
- Latency from accept to redirect_valid: ecall/interrupt 5 cycles, mret 3 cycles. At most one csr_we per cycle.
- Requests arriving while busy are held by the core (req_ready=0); mtip changes are ignored until IDLE.
- Back-to-back: an interrupt pending on the IDLE cycle after an mret redirect is taken only if the restored MIE=1.
- Reset mid-sequence aborts immediately; partial CSR writes are not rolled back.

Optional Feature:
VECTORED_MTVEC_EN
- Defined: when mtvec[1:0]=2'b01 and the trap is an interrupt, target = base + 4*cause[5:0] (timer: base+0x1c). Exceptions always use base.
- Undefined: mode bits are ignored; target is always base.

Decomposition:
- Shared package ysyx_22041412_csr_pkg holds:
  - CSR index localparams (mstatus..mip, ecall=0xb, mret=0xc);
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11;
  - cause constants;
  - the FSM state enum.
- One natural sub-module, ysyx_22041412_trap_target: combinational target computation including the vectored option.

Test Plan:
1. mtvec=0x8000_0100, ecall at pc 0x8000_0040 -> after 5 cycles: mepc=0x8000_0040, mcause=0xb, MIE=0, MPIE=old MIE, redirect_pc=0x8000_0100.
2. After test 1, mret -> after 3 cycles: MIE restored to 1, MPIE=1, redirect_pc=0x8000_0040.
3. mstatus.MIE=1, mie=0x80, mtip=1 and req_valid ecall in the same cycle -> irq_take=1, req_ready=0, mcause=0x8000_0000_0000_0007.
4. mtip=1 with MIE=0 -> no trap; ecall proceeds normally.
5. VECTORED_MTVEC_EN defined, mtvec=0x8000_0101, timer interrupt -> redirect_pc=0x8000_011c.
6. rst asserted in UPD_STATUS -> all outputs 0 asynchronously; FSM in IDLE; a new ecall after release completes normally.

Source files
------------

// File: rtl/ysyx_22041412_csr_pkg.sv
// Shared CSR indices, mstatus/mie bit positions, trap cause codes and the
// trap sequencer state encoding for the NPC machine-mode trap path.
package ysyx_22041412_csr_pkg;

    localparam int CSR_MSTATUS = 1;
    localparam int CSR_MIE     = 2;
    localparam int CSR_MTVEC   = 3;
    localparam int CSR_MEPC    = 4;
    localparam int CSR_MCAUSE  = 5;
    localparam int CSR_MIP     = 6;

    localparam int EXC_ECALL_M = 'hb;
    localparam int EXC_MRET    = 'hc;
    localparam int IRQ_MTI     = 7;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MIE_MTIE       = 7;

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        UPD_STATUS,
        RD_MTVEC,
        RESTORE,
        RD_MEPC,
        REDIRECT
    } trap_state_e;

endpackage

// File: rtl/ysyx_22041412_trap_ctrl_if.sv
// Trap controller bus: core commit requests, CLINT timer level, CSR file
// ports and the fetch redirect. master = core/CSR side, slave = trap_ctrl.
interface ysyx_22041412_trap_ctrl_if #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 3
);
    logic              req_valid;
    logic              req_type;
    logic [XLEN-1:0]   req_pc;
    logic              req_ready;
    logic              mtip;
    logic              irq_take;
    logic              busy;
    logic [CSR_AW-1:0] csr_raddr;
    logic [XLEN-1:0]   csr_rdata;
    logic              csr_we;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    modport master (
        output req_valid, req_type, req_pc, mtip, csr_rdata,
        input  req_ready, irq_take, busy, csr_raddr, csr_we, csr_waddr,
               csr_wdata, redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_type, req_pc, mtip, csr_rdata,
        output req_ready, irq_take, busy, csr_raddr, csr_we, csr_waddr,
               csr_wdata, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_22041412_trap_target.sv
// Trap vector computation from mtvec. With VECTORED_MTVEC_EN defined,
// interrupts in vectored mode jump to base + 4*cause; otherwise always base.
module ysyx_22041412_trap_target #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_mtvec,
    input  logic            i_is_irq,
    input  logic [5:0]      i_cause,
    output logic [XLEN-1:0] o_target
);
    logic [XLEN-1:0] w_base;
    assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef VECTORED_MTVEC_EN
    assign o_target = (i_is_irq && i_mtvec[1:0] == 2'b01)
                    ? w_base + XLEN'({i_cause, 2'b00}) : w_base;
`else
    logic w_unused;
    assign w_unused = ^{i_is_irq, i_cause, i_mtvec[1:0]};
    assign o_target = w_base;
`endif
endmodule

// File: rtl/ysyx_22041412_trap_ctrl.sv
// Machine-mode trap sequencer: ecall / mret / timer interrupt entry and
// return through the CSR file, then a fetch redirect. Option: VECTORED_MTVEC_EN.
module ysyx_22041412_trap_ctrl
    import ysyx_22041412_csr_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    ysyx_22041412_trap_ctrl_if.slave        bus
);
    localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(CSR_MSTATUS);
    localparam logic [CSR_AW-1:0] A_MIE     = CSR_AW'(CSR_MIE);
    localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(CSR_MTVEC);
    localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(CSR_MEPC);
    localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(CSR_MCAUSE);
    localparam logic [XLEN-1:0]   CAUSE_ECALL = XLEN'(EXC_ECALL_M);
    localparam logic [XLEN-1:0]   CAUSE_TIMER = {1'b1, (XLEN-1)'(IRQ_MTI)};

    trap_state_e       r_state;
    logic [CSR_AW-1:0] r_idle_raddr;
    logic              r_sh_mie;
    logic              r_sh_mtie;
    logic              r_is_irq;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_cause;
    logic [XLEN-1:0]   r_target;

    logic [XLEN-1:0]   w_rdata;
    logic [XLEN-1:0]   w_st_trap;
    logic [XLEN-1:0]   w_st_ret;
    logic [XLEN-1:0]   w_vec_target;
    logic              w_idle;
    logic              w_irq_pend;
    logic              w_we;
    logic [CSR_AW-1:0] w_waddr;
    logic [CSR_AW-1:0] w_raddr;
    logic [XLEN-1:0]   w_wdata;

    assign w_rdata    = bus.csr_rdata;
    assign w_idle     = (r_state == IDLE);
    // Shadows reset to 0, so no interrupt can be taken while rst is high.
    assign w_irq_pend = bus.mtip & r_sh_mie & r_sh_mtie;

    assign bus.irq_take       = w_idle & w_irq_pend;
    assign bus.req_ready      = w_idle & ~rst & bus.req_valid & ~w_irq_pend;
    assign bus.busy           = ~w_idle;
    assign bus.redirect_valid = (r_state == REDIRECT);
    assign bus.redirect_pc    = r_target;
    assign bus.csr_we         = w_we;
    assign bus.csr_waddr      = w_waddr;
    assign bus.csr_wdata      = w_wdata;
    assign bus.csr_raddr      = w_raddr;

    always_comb begin
        w_st_trap = w_rdata;
        w_st_trap[MSTATUS_MPIE] = w_rdata[MSTATUS_MIE];
        w_st_trap[MSTATUS_MIE]  = 1'b0;
        w_st_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        w_st_ret = w_rdata;
        w_st_ret[MSTATUS_MIE]   = w_rdata[MSTATUS_MPIE];
        w_st_ret[MSTATUS_MPIE]  = 1'b1;
        w_st_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // Read-modify-write states present mstatus and write it back in one cycle.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        w_raddr = w_idle ? r_idle_raddr : A_MSTATUS;
        case (r_state)
            SAVE_EPC:   begin w_we = 1'b1; w_waddr = A_MEPC;    w_wdata = r_pc;      end
            SAVE_CAUSE: begin w_we = 1'b1; w_waddr = A_MCAUSE;  w_wdata = r_cause;   end
            UPD_STATUS: begin w_we = 1'b1; w_waddr = A_MSTATUS; w_wdata = w_st_trap; end
            RESTORE:    begin w_we = 1'b1; w_waddr = A_MSTATUS; w_wdata = w_st_ret;  end
            RD_MTVEC:   w_raddr = A_MTVEC;
            RD_MEPC:    w_raddr = A_MEPC;
            default:    ;
        endcase
    end

    ysyx_22041412_trap_target #(.XLEN(XLEN)) u_target (
        .i_mtvec  (w_rdata),
        .i_is_irq (r_is_irq),
        .i_cause  (r_cause[5:0]),
        .o_target (w_vec_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idle_raddr <= '0;
            r_sh_mie     <= 1'b0;
            r_sh_mtie    <= 1'b0;
            r_is_irq     <= 1'b0;
            r_pc         <= '0;
            r_cause      <= '0;
            r_target     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Alternate mstatus/mie reads to keep the enable shadows fresh.
                    r_idle_raddr <= (r_idle_raddr == A_MSTATUS) ? A_MIE : A_MSTATUS;
                    if (r_idle_raddr == A_MSTATUS) r_sh_mie  <= w_rdata[MSTATUS_MIE];
                    if (r_idle_raddr == A_MIE)     r_sh_mtie <= w_rdata[MIE_MTIE];
                    if (w_irq_pend) begin
                        r_pc     <= bus.req_pc & ~XLEN'(1);
                        r_cause  <= CAUSE_TIMER;
                        r_is_irq <= 1'b1;
                        r_state  <= SAVE_EPC;
                    end else if (bus.req_valid && !bus.req_type) begin
                        r_pc     <= bus.req_pc & ~XLEN'(1);
                        r_cause  <= CAUSE_ECALL;
                        r_is_irq <= 1'b0;
                        r_state  <= SAVE_EPC;
                    end else if (bus.req_valid) begin
                        r_state  <= RESTORE;
                    end
                end
                SAVE_EPC:   r_state <= SAVE_CAUSE;
                SAVE_CAUSE: r_state <= UPD_STATUS;
                UPD_STATUS: begin
                    r_sh_mie <= 1'b0;
                    r_state  <= RD_MTVEC;
                end
                RD_MTVEC: begin
                    r_target <= w_vec_target;
                    r_state  <= REDIRECT;
                end
                // Shadow tracks the restored MIE so a back-to-back interrupt sees it.
                RESTORE: begin
                    r_sh_mie <= w_rdata[MSTATUS_MPIE];
                    r_state  <= RD_MEPC;
                end
                RD_MEPC: begin
                    r_target <= w_rdata;
                    r_state  <= REDIRECT;
                end
                REDIRECT: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22041412_trap_ctrl.sv
// Bench for the trap sequencer: CSR file model, directed scenarios and a
// randomized loop checked against a spec-level trap/return model.
module tb_ysyx_22041412_trap_ctrl;
    import ysyx_22041412_csr_pkg::*;
    localparam int XLEN = 64;
    localparam int CSR_AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22041412_trap_ctrl_if #(.XLEN(XLEN), .CSR_AW(CSR_AW)) bus();
    ysyx_22041412_trap_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] csr   [8];
    logic [63:0] m_csr [8];
    logic        tb_we;
    logic [2:0]  tb_waddr;
    logic [63:0] tb_wdata;
    int          chk_idx [3] = '{1, 4, 5};
    int          n_cmp = 0;
    int          n_err = 0;

    assign bus.csr_rdata = csr[bus.csr_raddr];
    always @(posedge clk) begin
        if (bus.csr_we) csr[bus.csr_waddr] <= bus.csr_wdata;
        if (tb_we)      csr[tb_waddr]      <= tb_wdata;
    end

    task automatic csr_set(input int idx, input logic [63:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = 3'(idx); tb_wdata = v;
        @(negedge clk);
        tb_we = 1'b0;
        m_csr[idx] = v;
    endtask

    // Model: trap entry rules applied to the model CSR array.
    task automatic model_trap(input logic [63:0] pc, input logic irq, output logic [63:0] tgt);
        logic [63:0] st;
        logic [63:0] cause;
        cause = irq ? 64'h8000_0000_0000_0007 : 64'hb;
        st = m_csr[1];
        st[7] = m_csr[1][3];
        st[3] = 1'b0;
        st[12:11] = 2'b11;
        m_csr[1] = st;
        m_csr[4] = pc & ~64'd1;
        m_csr[5] = cause;
        tgt = m_csr[3] & ~64'd3;
`ifdef VECTORED_MTVEC_EN
        if (irq && m_csr[3][1:0] == 2'b01) tgt = tgt + 4 * (cause & 64'h3f);
`endif
    endtask

    task automatic model_mret(output logic [63:0] tgt);
        logic [63:0] st;
        st = m_csr[1];
        st[3] = m_csr[1][7];
        st[7] = 1'b1;
        st[12:11] = 2'b11;
        m_csr[1] = st;
        tgt = m_csr[4];
    endtask

    task automatic drive_req(input logic v, input logic t, input logic [63:0] pc, input logic mt);
        repeat (4) @(negedge clk);
        bus.req_valid = v; bus.req_type = t; bus.req_pc = pc; bus.mtip = mt;
        #1;
    endtask

    // Counts edges from the accept edge until redirect_valid; -1 on timeout.
    task automatic wait_redirect(input logic keep_mtip, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                bus.req_valid = 1'b0;
                if (!keep_mtip) bus.mtip = 1'b0;
            end
            if (bus.redirect_valid) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_type = 1'b0; bus.req_pc = '0; bus.mtip = 1'b0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        for (int i = 0; i < 8; i++) csr_set(i, 64'h0);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.mtip = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.irq_take !== 1'b0) begin n_err++; $display("FAIL reset_irq_take got %b want 0", bus.irq_take); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.csr_we !== 1'b0) begin n_err++; $display("FAIL reset_csr_we got %b want 0", bus.csr_we); end
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_redirect_valid got %b want 0", bus.redirect_valid); end
        n_cmp++; if (bus.csr_raddr !== 3'd0) begin n_err++; $display("FAIL reset_csr_raddr got %0d want 0", bus.csr_raddr); end
        n_cmp++; if (bus.csr_waddr !== 3'd0) begin n_err++; $display("FAIL reset_csr_waddr got %0d want 0", bus.csr_waddr); end
        n_cmp++; if (bus.csr_wdata !== 64'd0) begin n_err++; $display("FAIL reset_csr_wdata got %h want 0", bus.csr_wdata); end
        n_cmp++; if (bus.redirect_pc !== 64'd0) begin n_err++; $display("FAIL reset_redirect_pc got %h want 0", bus.redirect_pc); end
        bus.req_valid = 1'b0; bus.mtip = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ecall_mret();
        logic [63:0] tgt;
        int n;
        csr_set(1, 64'h8); csr_set(2, 64'h0); csr_set(3, 64'h8000_0100);
        drive_req(1'b1, 1'b0, 64'h8000_0040, 1'b0);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL ecall_ready got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.irq_take !== 1'b0) begin n_err++; $display("FAIL ecall_irq_take got %b want 0", bus.irq_take); end
        model_trap(64'h8000_0040, 1'b0, tgt);
        wait_redirect(1'b0, n);
        n_cmp++; if (n !== 5) begin n_err++; $display("FAIL ecall_latency got %0d want 5", n); end
        n_cmp++; if (bus.redirect_pc !== 64'h8000_0100) begin n_err++; $display("FAIL ecall_target got %h want %h", bus.redirect_pc, 64'h8000_0100); end
        n_cmp++; if (csr[1][7:3] !== 5'b10000) begin n_err++; $display("FAIL ecall_mpie_mie got %b want 10000", csr[1][7:3]); end
        foreach (chk_idx[k]) begin
            n_cmp++;
            if (csr[chk_idx[k]] !== m_csr[chk_idx[k]]) begin n_err++; $display("FAIL ecall_csr[%0d] got %h want %h", chk_idx[k], csr[chk_idx[k]], m_csr[chk_idx[k]]); end
        end
        drive_req(1'b1, 1'b1, 64'h0, 1'b0);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL mret_ready got %b want 1", bus.req_ready); end
        model_mret(tgt);
        wait_redirect(1'b0, n);
        n_cmp++; if (n !== 3) begin n_err++; $display("FAIL mret_latency got %0d want 3", n); end
        n_cmp++; if (bus.redirect_pc !== 64'h8000_0040) begin n_err++; $display("FAIL mret_target got %h want %h", bus.redirect_pc, 64'h8000_0040); end
        n_cmp++; if (csr[1] !== m_csr[1]) begin n_err++; $display("FAIL mret_mstatus got %h want %h", csr[1], m_csr[1]); end
    endtask

    task automatic test_irq_priority();
        logic [63:0] tgt;
        int n;
        csr_set(1, 64'h8); csr_set(2, 64'h80); csr_set(3, 64'h8000_0200);
        drive_req(1'b1, 1'b0, 64'h8000_0088, 1'b1);
        n_cmp++; if (bus.irq_take !== 1'b1) begin n_err++; $display("FAIL irq_take got %b want 1", bus.irq_take); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL irq_req_ready got %b want 0", bus.req_ready); end
        model_trap(64'h8000_0088, 1'b1, tgt);
        wait_redirect(1'b0, n);
        n_cmp++; if (n !== 5) begin n_err++; $display("FAIL irq_latency got %0d want 5", n); end
        n_cmp++; if (bus.redirect_pc !== tgt) begin n_err++; $display("FAIL irq_target got %h want %h", bus.redirect_pc, tgt); end
        n_cmp++; if (csr[5] !== 64'h8000_0000_0000_0007) begin n_err++; $display("FAIL irq_mcause got %h want 8000000000000007", csr[5]); end
        n_cmp++; if (csr[1] !== m_csr[1]) begin n_err++; $display("FAIL irq_mstatus got %h want %h", csr[1], m_csr[1]); end
    endtask

    task automatic test_irq_masked();
        logic [63:0] tgt;
        int n;
        csr_set(1, 64'h0); csr_set(2, 64'h80); csr_set(3, 64'h8000_0300);
        drive_req(1'b1, 1'b0, 64'h8000_0090, 1'b1);
        n_cmp++; if (bus.irq_take !== 1'b0) begin n_err++; $display("FAIL masked_irq_take got %b want 0", bus.irq_take); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL masked_ready got %b want 1", bus.req_ready); end
        model_trap(64'h8000_0090, 1'b0, tgt);
        wait_redirect(1'b1, n);
        n_cmp++; if (n !== 5) begin n_err++; $display("FAIL masked_latency got %0d want 5", n); end
        n_cmp++; if (csr[5] !== 64'hb) begin n_err++; $display("FAIL masked_mcause got %h want b", csr[5]); end
        @(posedge clk); #1;
        n_cmp++; if (bus.irq_take !== 1'b0) begin n_err++; $display("FAIL masked_after got %b want 0", bus.irq_take); end
        bus.mtip = 1'b0;
    endtask

    task automatic test_vectored();
        logic [63:0] tgt;
        logic [63:0] want;
        int n;
`ifdef VECTORED_MTVEC_EN
        want = 64'h8000_011c;
`else
        want = 64'h8000_0100;
`endif
        csr_set(1, 64'h8); csr_set(2, 64'h80); csr_set(3, 64'h8000_0101);
        drive_req(1'b0, 1'b0, 64'h8000_0044, 1'b1);
        n_cmp++; if (bus.irq_take !== 1'b1) begin n_err++; $display("FAIL vec_irq_take got %b want 1", bus.irq_take); end
        model_trap(64'h8000_0044, 1'b1, tgt);
        wait_redirect(1'b0, n);
        n_cmp++; if (bus.redirect_pc !== want) begin n_err++; $display("FAIL vec_target got %h want %h", bus.redirect_pc, want); end
        n_cmp++; if (csr[4] !== m_csr[4]) begin n_err++; $display("FAIL vec_mepc got %h want %h", csr[4], m_csr[4]); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] tgt;
        int n;
        csr_set(1, 64'h80); csr_set(2, 64'h80); csr_set(3, 64'h8000_0400); csr_set(4, 64'h8000_0300);
        drive_req(1'b1, 1'b1, 64'h0, 1'b1);
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.irq_take !== 1'b0) begin n_err++; $display("FAIL b2b_accept got %b%b want 10", bus.req_ready, bus.irq_take); end
        model_mret(tgt);
        bus.req_pc = 64'h8000_0300;
        wait_redirect(1'b1, n);
        n_cmp++; if (n !== 3 || bus.redirect_pc !== tgt) begin n_err++; $display("FAIL b2b_mret got %0d/%h want 3/%h", n, bus.redirect_pc, tgt); end
        @(posedge clk); #1;
        n_cmp++; if (bus.irq_take !== 1'b1) begin n_err++; $display("FAIL b2b_irq_take got %b want 1", bus.irq_take); end
        model_trap(64'h8000_0300, 1'b1, tgt);
        wait_redirect(1'b0, n);
        n_cmp++; if (n !== 5 || bus.redirect_pc !== tgt) begin n_err++; $display("FAIL b2b_irq got %0d/%h want 5/%h", n, bus.redirect_pc, tgt); end
        n_cmp++; if (csr[4] !== 64'h8000_0300) begin n_err++; $display("FAIL b2b_mepc got %h want 80000300", csr[4]); end
        // Restored MIE=0: the pending timer must stay untaken.
        csr_set(1, 64'h0);
        drive_req(1'b1, 1'b1, 64'h0, 1'b1);
        model_mret(tgt);
        wait_redirect(1'b1, n);
        @(posedge clk); #1;
        n_cmp++; if (bus.irq_take !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_masked got %b%b want 00", bus.irq_take, bus.busy); end
        bus.mtip = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [63:0] tgt;
        int n;
        csr_set(1, 64'h8); csr_set(2, 64'h0); csr_set(3, 64'h8000_0100);
        drive_req(1'b1, 1'b0, 64'h8000_0080, 1'b0);
        @(posedge clk); #1; bus.req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b1 || bus.csr_we !== 1'b1) begin n_err++; $display("FAIL midrst_pre got %b%b want 11", bus.busy, bus.csr_we); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({bus.busy, bus.csr_we, bus.redirect_valid, bus.req_ready, bus.irq_take} !== 5'b0) begin n_err++; $display("FAIL midrst_ctrl got %b want 00000", {bus.busy, bus.csr_we, bus.redirect_valid, bus.req_ready, bus.irq_take}); end
        n_cmp++; if ({bus.csr_raddr, bus.csr_waddr} !== 6'd0 || bus.csr_wdata !== 64'd0 || bus.redirect_pc !== 64'd0) begin n_err++; $display("FAIL midrst_data got %0d %0d %h %h want 0", bus.csr_raddr, bus.csr_waddr, bus.csr_wdata, bus.redirect_pc); end
        m_csr[4] = 64'h8000_0080;
        m_csr[5] = 64'hb;
        foreach (chk_idx[k]) begin
            n_cmp++;
            if (csr[chk_idx[k]] !== m_csr[chk_idx[k]]) begin n_err++; $display("FAIL midrst_csr[%0d] got %h want %h", chk_idx[k], csr[chk_idx[k]], m_csr[chk_idx[k]]); end
        end
        @(negedge clk);
        rst = 1'b0;
        drive_req(1'b1, 1'b0, 64'h8000_00c4, 1'b0);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", bus.req_ready); end
        model_trap(64'h8000_00c4, 1'b0, tgt);
        wait_redirect(1'b0, n);
        n_cmp++; if (n !== 5 || bus.redirect_pc !== tgt) begin n_err++; $display("FAIL midrst_ecall got %0d/%h want 5/%h", n, bus.redirect_pc, tgt); end
        n_cmp++; if (csr[1] !== m_csr[1]) begin n_err++; $display("FAIL midrst_mstatus got %h want %h", csr[1], m_csr[1]); end
    endtask

    task automatic test_random();
        logic [63:0] st, ie, tv, ep, pc, tgt;
        logic rv, rt, mt, irq;
        int n, lat;
        for (int it = 0; it < 40; it++) begin
            st = {$urandom, $urandom};
            ie = {$urandom, $urandom};
            tv = {$urandom, $urandom};
            tv[1:0] = 2'($urandom_range(0, 1));
            ep = {$urandom, $urandom} & ~64'd1;
            pc = {$urandom, $urandom};
            rv = 1'($urandom_range(0, 1));
            rt = 1'($urandom_range(0, 1));
            mt = 1'($urandom_range(0, 1));
            csr_set(1, st); csr_set(2, ie); csr_set(3, tv); csr_set(4, ep);
            irq = mt & st[3] & ie[7];
            drive_req(rv, rt, pc, mt);
            n_cmp++; if (bus.irq_take !== irq) begin n_err++; $display("FAIL rnd%0d_irq_take got %b want %b", it, bus.irq_take, irq); end
            n_cmp++; if (bus.req_ready !== (rv & ~irq)) begin n_err++; $display("FAIL rnd%0d_ready got %b want %b", it, bus.req_ready, rv & ~irq); end
            if (irq || rv) begin
                lat = (irq || !rt) ? 5 : 3;
                if (lat == 5) model_trap(pc, irq, tgt);
                else model_mret(tgt);
                wait_redirect(1'b0, n);
                n_cmp++; if (n !== lat) begin n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", it, n, lat); end
                n_cmp++; if (bus.redirect_pc !== tgt) begin n_err++; $display("FAIL rnd%0d_target got %h want %h", it, bus.redirect_pc, tgt); end
                foreach (chk_idx[k]) begin
                    n_cmp++;
                    if (csr[chk_idx[k]] !== m_csr[chk_idx[k]]) begin n_err++; $display("FAIL rnd%0d_csr[%0d] got %h want %h", it, chk_idx[k], csr[chk_idx[k]], m_csr[chk_idx[k]]); end
                end
            end else begin
                @(posedge clk); #1;
                bus.req_valid = 1'b0; bus.mtip = 1'b0;
                n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rnd%0d_idle_busy got %b want 0", it, bus.busy); end
            end
            @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_ecall_mret();
        test_irq_priority();
        test_irq_masked();
        test_vectored();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
